// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin front end for one shared combinational FP32
// multiplier. One request is granted at a time. Its operands are held for
// MUL_CYCLES cycles so the multiplier output can settle. The product and
// status are then captured and returned on a valid/ready response channel.
module fp_mul_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_c,
  input  logic [4:0]            mul_state,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_c,
  output logic [4:0]            rsp_state,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The settling counter counts down to zero, so EXEC lasts MUL_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_c_q, rsp_c_d;
  logic [4:0]      rsp_state_q, rsp_state_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  int              cand;

  // Round-robin search: the first valid requester after the last winner.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Next-state logic and the combinational grant strobe.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_c_d      = rsp_c_q;
    rsp_state_d  = rsp_state_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        // req_ready is only raised for a valid requester, so a grant is a transfer.
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          mul_a_d              = req_a[32*grant_idx +: 32];
          mul_b_d              = req_b[32*grant_idx +: 32];
          rsp_id_d             = grant_idx;
          last_grant_d         = grant_idx;
          cnt_d                = CNT_LOAD;
          state_d              = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_c_d     = mul_c;
          rsp_state_d = mul_state;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      rsp_id_q     <= '0;
      rsp_c_q      <= 32'd0;
      rsp_state_q  <= 5'd0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_c_q      <= rsp_c_d;
      rsp_state_q  <= rsp_state_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_state = rsp_state_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
